// File: rtl/shift_arbiter_pkg.sv
// Shared constants for the two-requester shift arbiter: mode encodings and requester count.
package shift_arbiter_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        MODE_SLL = 2'b00,
        MODE_SRA = 2'b01,
        MODE_ROL = 2'b10,
        MODE_ROR = 2'b11
    } shift_mode_e;

endpackage

// File: rtl/shift_arbiter_barrel_shifter.sv
// Combinational log-depth barrel shifter: stage gi shifts/rotates by 2**gi when amount bit gi is set.
module barrel_shifter
    import shift_arbiter_pkg::*;
#(
    parameter int DSIZE = 64,
    parameter int ASIZE = 6
) (
    input  logic [DSIZE-1:0] data_i,
    input  logic [ASIZE-1:0] amount_i,
    input  logic [1:0]       mode_i,
    output logic [DSIZE-1:0] result_o
);

    shift_mode_e      mode;
    logic [DSIZE-1:0] stage [ASIZE+1];

    assign mode     = shift_mode_e'(mode_i);
    assign stage[0] = data_i;

    for (genvar gi = 0; gi < ASIZE; gi++) begin : g_stage
        localparam int SH = 1 << gi;
        logic [DSIZE-1:0] sll_w;
        logic [DSIZE-1:0] sra_w;
        logic [DSIZE-1:0] rol_w;
        logic [DSIZE-1:0] ror_w;

        // The sign bit survives every arithmetic stage, so each stage may fill from its own MSB.
        assign sll_w = {stage[gi][DSIZE-1-SH:0], {SH{1'b0}}};
        assign sra_w = {{SH{stage[gi][DSIZE-1]}}, stage[gi][DSIZE-1:SH]};
        assign rol_w = {stage[gi][DSIZE-1-SH:0], stage[gi][DSIZE-1:DSIZE-SH]};
        assign ror_w = {stage[gi][SH-1:0], stage[gi][DSIZE-1:SH]};

        assign stage[gi+1] = !amount_i[gi]      ? stage[gi] :
                             (mode == MODE_SLL) ? sll_w     :
                             (mode == MODE_SRA) ? sra_w     :
                             (mode == MODE_ROL) ? rol_w     : ror_w;
    end

    assign result_o = stage[ASIZE];

endmodule

// File: rtl/shift_arbiter.sv
// Two-requester round-robin front end sharing one barrel shifter, with a single
// result register that can be refilled in the same cycle it is drained.
module shift_arbiter
    import shift_arbiter_pkg::*;
#(
    parameter int DSIZE = 64,
    parameter int ASIZE = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*DSIZE-1:0]   req_data,
    input  logic [NUM_REQ*ASIZE-1:0]   req_amount,
    input  logic [NUM_REQ*2-1:0]       req_mode,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DSIZE-1:0]           rsp_data,
    output logic                       rsp_id
);

    logic [DSIZE-1:0] data_arr [NUM_REQ];
    logic [ASIZE-1:0] amt_arr  [NUM_REQ];
    logic [1:0]       mode_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign data_arr[gi] = req_data[gi*DSIZE +: DSIZE];
        assign amt_arr[gi]  = req_amount[gi*ASIZE +: ASIZE];
        assign mode_arr[gi] = req_mode[gi*2 +: 2];
    end

    logic             rsp_valid_q, rsp_valid_d;
    logic [DSIZE-1:0] rsp_data_q,  rsp_data_d;
    logic             rsp_id_q,    rsp_id_d;
    logic             ptr_q,       ptr_d;

    logic             slot_free;
    logic             grant_id;
    logic             accept;
    logic [DSIZE-1:0] shift_result;

    // Grant depends only on handshake state and the pointer, never on payload.
    always_comb begin
        slot_free = !rsp_valid_q || rsp_ready;
        req_ready = '0;
        grant_id  = 1'b0;
        if (!rst && slot_free) begin
            unique case (req_valid)
                2'b01: begin
                    req_ready = 2'b01;
                    grant_id  = 1'b0;
                end
                2'b10: begin
                    req_ready = 2'b10;
                    grant_id  = 1'b1;
                end
                2'b11: begin
                    grant_id  = ~ptr_q;
                    req_ready = ptr_q ? 2'b01 : 2'b10;
                end
                default: ;
            endcase
        end
    end

    assign accept = |req_ready;

    barrel_shifter #(
        .DSIZE(DSIZE),
        .ASIZE(ASIZE)
    ) u_shifter (
        .data_i  (data_arr[grant_id]),
        .amount_i(amt_arr[grant_id]),
        .mode_i  (mode_arr[grant_id]),
        .result_o(shift_result)
    );

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        ptr_d       = ptr_q;
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = shift_result;
            rsp_id_d    = grant_id;
            ptr_d       = grant_id;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // Pointer resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= 1'b0;
            ptr_q       <= 1'b1;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            ptr_q       <= ptr_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed vector table, hand-written stall/reset
// sequences, then randomized traffic against a behavioural reference model.
module tb_shift_arbiter;

    localparam int DSIZE = 64;
    localparam int ASIZE = 6;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [1:0]           req_valid = '0;
    logic [1:0]           req_ready;
    logic [2*DSIZE-1:0]   req_data = '0;
    logic [2*ASIZE-1:0]   req_amount = '0;
    logic [3:0]           req_mode = '0;
    logic                 rsp_valid;
    logic                 rsp_ready = 1'b0;
    logic [DSIZE-1:0]     rsp_data;
    logic                 rsp_id;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shift_arbiter #(.DSIZE(DSIZE), .ASIZE(ASIZE)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_amount(req_amount),
        .req_mode  (req_mode),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
    );

    typedef struct {
        logic [1:0]  v;
        logic [63:0] d0;
        logic [63:0] d1;
        int          a0;
        int          a1;
        logic [1:0]  m0;
        logic [1:0]  m1;
        logic [1:0]  exp_ready;
        logic        exp_valid;
        logic [63:0] exp_data;
        logic        exp_id;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference semantics straight from the mode definitions.
    function automatic logic [63:0] ref_shift(input logic [63:0] d, input int a, input logic [1:0] m);
        logic [63:0] r;
        case (m)
            2'b00:   r = d << a;
            2'b01:   r = $signed(d) >>> a;
            2'b10:   r = (a == 0) ? d : ((d << a) | (d >> (64 - a)));
            default: r = (a == 0) ? d : ((d >> a) | (d << (64 - a)));
        endcase
        return r;
    endfunction

    task automatic drive(input logic [1:0] v, input logic [63:0] d0, input logic [63:0] d1,
                         input int a0, input int a1, input logic [1:0] m0, input logic [1:0] m1,
                         input logic rr, input logic r);
        rst        = r;
        req_valid  = v;
        req_data   = {d1, d0};
        req_amount = {6'(a1), 6'(a0)};
        req_mode   = {m1, m0};
        rsp_ready  = rr;
    endtask

    // One clock: drive at negedge, check ready before the edge, check result after it.
    task automatic step(input string name, input logic [1:0] v, input logic [63:0] d0,
                        input logic [63:0] d1, input int a0, input int a1,
                        input logic [1:0] m0, input logic [1:0] m1, input logic rr, input logic r,
                        input logic [1:0] exp_ready, input logic exp_valid,
                        input logic [63:0] exp_data, input logic exp_id);
        @(negedge clk);
        drive(v, d0, d1, a0, a1, m0, m1, rr, r);
        #1;
        check({name, ".ready"}, 64'(req_ready), 64'(exp_ready));
        @(posedge clk);
        #1;
        check({name, ".valid"}, 64'(rsp_valid), 64'(exp_valid));
        if (exp_valid || r) begin
            check({name, ".data"}, rsp_data, exp_data);
            check({name, ".id"}, 64'(rsp_id), 64'(exp_id));
        end
        $display("[%0t] %s ready=%b rsp_valid=%b rsp_data=%h rsp_id=%0d",
                 $time, name, req_ready, rsp_valid, rsp_data, rsp_id);
    endtask

    logic        m_valid;
    logic [63:0] m_data;
    logic        m_id;
    logic        m_last;

    initial begin
        // Tie after reset: requester 0 first, then alternation.
        tbl[0] = '{2'b11, 64'h80000000_00000000, 64'h3, 8, 1, 2'b10, 2'b00, 2'b01, 1'b1, 64'h80, 1'b0};
        tbl[1] = '{2'b11, 64'h80000000_00000000, 64'h3, 8, 1, 2'b10, 2'b00, 2'b10, 1'b1, 64'h6,  1'b1};
        tbl[2] = '{2'b11, 64'h80000000_00000000, 64'h3, 8, 1, 2'b10, 2'b00, 2'b01, 1'b1, 64'h80, 1'b0};
        tbl[3] = '{2'b11, 64'h80000000_00000000, 64'h3, 8, 1, 2'b10, 2'b00, 2'b10, 1'b1, 64'h6,  1'b1};
        tbl[4] = '{2'b01, 64'h1, 64'h0, 4, 0, 2'b00, 2'b00, 2'b01, 1'b1, 64'h10, 1'b0};
        tbl[5] = '{2'b10, 64'h0, 64'hDEADBEEF_01234567, 0, 0, 2'b00, 2'b11, 2'b10, 1'b1, 64'hDEADBEEF_01234567, 1'b1};
        tbl[6] = '{2'b01, 64'hDEADBEEF_01234567, 64'h0, 63, 0, 2'b11, 2'b00, 2'b01, 1'b1, 64'hBD5B7DDE_02468ACF, 1'b0};
        tbl[7] = '{2'b10, 64'h0, 64'hF0000000_00000000, 0, 4, 2'b00, 2'b01, 2'b10, 1'b1, 64'hFF000000_00000000, 1'b1};
        tbl[8] = '{2'b01, 64'h80000000_00000000, 64'h0, 63, 0, 2'b01, 2'b00, 2'b01, 1'b1, 64'hFFFFFFFF_FFFFFFFF, 1'b0};
        tbl[9] = '{2'b00, 64'h0, 64'h0, 0, 0, 2'b00, 2'b00, 2'b00, 1'b0, 64'h0, 1'b0};

        // Reset with both requesters asserting: nothing may be accepted.
        for (int i = 0; i < 2; i++)
            step("reset", 2'b11, 64'h5, 64'h7, 1, 1, 2'b00, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 64'h0, 1'b0);

        for (int i = 0; i < 10; i++)
            step($sformatf("vec%0d", i), tbl[i].v, tbl[i].d0, tbl[i].d1, tbl[i].a0, tbl[i].a1,
                 tbl[i].m0, tbl[i].m1, 1'b1, 1'b0, tbl[i].exp_ready, tbl[i].exp_valid,
                 tbl[i].exp_data, tbl[i].exp_id);

        // Stall: held result stays put and no grant is issued until the consumer is ready.
        step("stall_load", 2'b01, 64'h1, 64'h3, 4, 1, 2'b00, 2'b00, 1'b1, 1'b0, 2'b01, 1'b1, 64'h10, 1'b0);
        for (int i = 0; i < 5; i++)
            step($sformatf("stall%0d", i), 2'b11, 64'h1, 64'h3, 4, 1, 2'b00, 2'b00, 1'b0, 1'b0,
                 2'b00, 1'b1, 64'h10, 1'b0);
        step("stall_release", 2'b10, 64'h1, 64'h3, 4, 1, 2'b00, 2'b00, 1'b1, 1'b0, 2'b10, 1'b1, 64'h6, 1'b1);

        // Reset in the middle of a stall discards the held result and re-arms the pointer.
        step("rst_hold", 2'b00, 64'h0, 64'h0, 0, 0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 64'h6, 1'b1);
        step("rst_pulse", 2'b11, 64'h1, 64'h3, 4, 1, 2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 64'h0, 1'b0);
        step("rst_tie", 2'b11, 64'h80000000_00000000, 64'h3, 8, 1, 2'b10, 2'b00, 1'b1, 1'b0,
             2'b01, 1'b1, 64'h80, 1'b0);

        // Randomized traffic against the reference model, starting from a clean reset.
        step("rand_reset", 2'b00, 64'h0, 64'h0, 0, 0, 2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 64'h0, 1'b0);
        m_valid = 1'b0;
        m_data  = '0;
        m_id    = 1'b0;
        m_last  = 1'b1;
        for (int n = 0; n < 400; n++) begin
            logic [1:0]  v;
            logic [63:0] d [2];
            int          a [2];
            logic [1:0]  m [2];
            logic        rr;
            logic        r;
            logic [1:0]  exp_ready;
            int          winner;
            v  = 2'($urandom_range(0, 3));
            for (int k = 0; k < 2; k++) begin
                d[k] = {$urandom, $urandom};
                a[k] = $urandom_range(0, 63);
                m[k] = 2'($urandom_range(0, 3));
            end
            rr = ($urandom_range(0, 3) != 0);
            r  = ($urandom_range(0, 49) == 0);

            @(negedge clk);
            drive(v, d[0], d[1], a[0], a[1], m[0], m[1], rr, r);
            winner    = (v == 2'b11) ? (1 - int'(m_last)) : (v[0] ? 0 : 1);
            exp_ready = (r || v == 2'b00 || (m_valid && !rr)) ? 2'b00 : 2'(1 << winner);
            #1;
            check("rand.ready", 64'(req_ready), 64'(exp_ready));

            @(posedge clk);
            if (r) begin
                m_valid = 1'b0;
                m_data  = '0;
                m_id    = 1'b0;
                m_last  = 1'b1;
            end else if (exp_ready != 2'b00) begin
                m_valid = 1'b1;
                m_data  = ref_shift(d[winner], a[winner], m[winner]);
                m_id    = winner[0];
                m_last  = winner[0];
            end else if (rr) begin
                m_valid = 1'b0;
            end
            #1;
            check("rand.valid", 64'(rsp_valid), 64'(m_valid));
            if (m_valid) begin
                check("rand.data", rsp_data, m_data);
                check("rand.id", 64'(rsp_id), 64'(m_id));
            end
            $display("[%0t] rand%0d v=%b rst=%b ready=%b rsp_valid=%b rsp_data=%h rsp_id=%0d",
                     $time, n, v, r, req_ready, rsp_valid, rsp_data, rsp_id);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
